// File: rtl/sp_preproc_ctrl_pkg.sv
// Shared definitions for the pixel pre-processing controller: register map,
// CTRL bit positions, reset defaults, FSM encoding and the background IIR step.
package sp_preproc_ctrl_pkg;

    // Configuration register addresses
    localparam logic [1:0] ADDR_HIGH_TH = 2'd0;
    localparam logic [1:0] ADDR_LOW_TH  = 2'd1;
    localparam logic [1:0] ADDR_BG_INIT = 2'd2;
    localparam logic [1:0] ADDR_CTRL    = 2'd3;

    // CTRL register bit positions
    localparam int CTRL_EN       = 0;
    localparam int CTRL_DET_HIGH = 1;
    localparam int CTRL_DET_LOW  = 2;
    localparam int CTRL_ADAPT    = 3;

    // Reset defaults
    localparam logic [7:0]  RST_HIGH_TH = 8'd250;
    localparam logic [7:0]  RST_LOW_TH  = 8'd5;
    localparam logic [7:0]  RST_BG_INIT = 8'd186;
    localparam logic [3:0]  RST_CTRL    = 4'b0011;
    localparam logic [15:0] RST_ACC     = {RST_BG_INIT, 8'h00};

    // Upper clamp of the background accumulator (8.8 fixed point, max 255.0)
    localparam logic [15:0] ACC_MAX = 16'hFF00;

    // FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // One IIR step: acc + ((pix<<8) - acc) >>> sh, clamped to 0..ACC_MAX.
    // 18-bit signed intermediates keep both the difference and the sum exact.
    function automatic logic [15:0] acc_step(input logic [15:0] acc,
                                             input logic [7:0]  pix,
                                             input logic [2:0]  sh);
        logic signed [17:0] diff;
        logic signed [17:0] sum;
        diff = $signed({2'b00, pix, 8'h00}) - $signed({2'b00, acc});
        sum  = $signed({2'b00, acc}) + (diff >>> sh);
        if (sum[17]) begin
            return 16'h0000;
        end else if (sum > $signed({2'b00, ACC_MAX})) begin
            return ACC_MAX;
        end else begin
            return sum[15:0];
        end
    endfunction

endpackage

// File: rtl/sp_frame_counter.sv
// Column/row position tracker for the incoming pixel stream. Advances only
// on accepted pixels and flags the last pixel of a line and of a frame.
module sp_frame_counter #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1,
    parameter int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic adv_i,
    output logic eol_o,
    output logic last_o
);

    logic [COL_W-1:0] col_q;
    logic [ROW_W-1:0] row_q;
    logic [COL_W-1:0] col_d;
    logic [ROW_W-1:0] row_d;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    // Position flags decoded from the current counter values
    always_comb begin
        eol_o  = (col_q == COL_LAST);
        last_o = eol_o && (row_q == ROW_LAST);
    end

    // Next position: wrap column at end of line, wrap row at end of frame
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (adv_i) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Position registers
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

endmodule

// File: rtl/sp_preproc_ctrl.sv
// Pixel pre-processing controller: replaces out-of-range pixels with an
// adaptive background level, frames the output stream and reports status.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for staged enable; nothing accepted
// RUN   | streaming a frame with the active (frozen) configuration
// DONE  | single-cycle end of frame; frame_done pulses, reload or idle
module sp_preproc_ctrl
    import sp_preproc_ctrl_pkg::*;
#(
    parameter int IMG_W    = 640,
    parameter int IMG_H    = 480,
    parameter int ALPHA_SH = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        cfg_we,
    input  logic [1:0]  cfg_addr,
    input  logic [7:0]  cfg_wdata,

    input  logic        s_valid,
    output logic        s_ready,
    input  logic [7:0]  s_data,

    output logic        m_valid,
    input  logic        m_ready,
    output logic [7:0]  m_data,
    output logic        m_eol,
    output logic        m_eof,

    output logic        busy,
    output logic        frame_done,
    output logic [19:0] hit_count,
    output logic [7:0]  bg_level
);

    localparam logic [2:0] SH = 3'(ALPHA_SH);

    // Staged configuration (written by software at any time)
    logic [7:0]  stg_high_q;
    logic [7:0]  stg_low_q;
    logic [7:0]  stg_bg_q;
    logic [3:0]  stg_ctrl_q;
    logic        acc_pend_q;

    // Active configuration (frozen for the duration of a frame)
    logic [7:0]  act_high_q;
    logic [7:0]  act_low_q;
    logic        act_det_high_q;
    logic        act_det_low_q;
    logic        act_adapt_q;
    logic [7:0]  bg_q;

    logic [15:0] acc_q;
    logic [15:0] acc_d;
    logic [19:0] hit_cnt_q;

    state_e      state_q;
    logic        busy_q;
    logic        frame_done_q;

    logic        m_valid_q;
    logic [7:0]  m_data_q;
    logic        m_eol_q;
    logic        m_eof_q;

    logic        load;
    logic        accept;
    logic        hit;
    logic        eol_w;
    logic        last_w;
    logic        wr_bg;
    logic [15:0] load_acc;

    sp_frame_counter #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) u_frame_counter (
        .clk    (clk),
        .rst    (rst),
        .adv_i  (accept),
        .eol_o  (eol_w),
        .last_o (last_w)
    );

    // Handshake, hit decision and frame-load qualifiers
    always_comb begin
        s_ready  = (state_q == ST_RUN) && (!m_valid_q || m_ready);
        accept   = s_valid && s_ready;
        hit      = (act_det_high_q && (s_data >= act_high_q)) ||
                   (act_det_low_q  && (s_data <= act_low_q));
        load     = stg_ctrl_q[CTRL_EN] &&
                   ((state_q == ST_IDLE) || (state_q == ST_DONE));
        wr_bg    = cfg_we && (cfg_addr == ADDR_BG_INIT);
        // A pending BG_INIT write overrides whatever the IIR has reached
        load_acc = acc_pend_q ? {stg_bg_q, 8'h00} : acc_q;
    end

    // Staging registers; a write coinciding with a load is only seen next load
    always_ff @(posedge clk) begin
        if (rst) begin
            stg_high_q <= RST_HIGH_TH;
            stg_low_q  <= RST_LOW_TH;
            stg_bg_q   <= RST_BG_INIT;
            stg_ctrl_q <= RST_CTRL;
            acc_pend_q <= 1'b0;
        end else begin
            if (cfg_we) begin
                case (cfg_addr)
                    ADDR_HIGH_TH: stg_high_q <= cfg_wdata;
                    ADDR_LOW_TH:  stg_low_q  <= cfg_wdata;
                    ADDR_BG_INIT: stg_bg_q   <= cfg_wdata;
                    ADDR_CTRL:    stg_ctrl_q <= cfg_wdata[3:0];
                    default:      ;
                endcase
            end
            if (wr_bg) begin
                acc_pend_q <= 1'b1;
            end else if (load) begin
                acc_pend_q <= 1'b0;
            end
        end
    end

    // Control FSM with registered busy/frame_done
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    frame_done_q <= 1'b0;
                    if (stg_ctrl_q[CTRL_EN]) begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    busy_q <= 1'b1;
                    if (accept && last_w) begin
                        state_q      <= ST_DONE;
                        frame_done_q <= 1'b1;
                    end else begin
                        frame_done_q <= 1'b0;
                    end
                end
                ST_DONE: begin
                    frame_done_q <= 1'b0;
                    if (stg_ctrl_q[CTRL_EN]) begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    busy_q       <= 1'b0;
                    frame_done_q <= 1'b0;
                end
            endcase
        end
    end

    // Next accumulator value: reload at frame start, adapt on non-hit pixels
    always_comb begin
        acc_d = acc_q;
        if (load) begin
            acc_d = load_acc;
        end else if (accept && !hit && act_adapt_q) begin
            acc_d = acc_step(acc_q, s_data, SH);
        end
    end

    // Active configuration, background level and accumulator
    always_ff @(posedge clk) begin
        if (rst) begin
            act_high_q     <= RST_HIGH_TH;
            act_low_q      <= RST_LOW_TH;
            act_det_high_q <= RST_CTRL[CTRL_DET_HIGH];
            act_det_low_q  <= RST_CTRL[CTRL_DET_LOW];
            act_adapt_q    <= RST_CTRL[CTRL_ADAPT];
            bg_q           <= RST_BG_INIT;
            acc_q          <= RST_ACC;
        end else begin
            acc_q <= acc_d;
            if (load) begin
                act_high_q     <= stg_high_q;
                act_low_q      <= stg_low_q;
                act_det_high_q <= stg_ctrl_q[CTRL_DET_HIGH];
                act_det_low_q  <= stg_ctrl_q[CTRL_DET_LOW];
                act_adapt_q    <= stg_ctrl_q[CTRL_ADAPT];
                bg_q           <= load_acc[15:8];
            end
        end
    end

    // Saturating per-frame hit counter
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q <= '0;
        end else if (load) begin
            hit_cnt_q <= '0;
        end else if (accept && hit && (hit_cnt_q != 20'hFFFFF)) begin
            hit_cnt_q <= hit_cnt_q + 20'd1;
        end
    end

    // Output register: capture on accept, hold until consumed
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid_q <= 1'b0;
            m_data_q  <= 8'h00;
            m_eol_q   <= 1'b0;
            m_eof_q   <= 1'b0;
        end else if (accept) begin
            m_valid_q <= 1'b1;
            m_data_q  <= hit ? bg_q : s_data;
            m_eol_q   <= eol_w;
            m_eof_q   <= last_w;
        end else if (m_ready) begin
            m_valid_q <= 1'b0;
        end
    end

    // Status and stream outputs
    always_comb begin
        m_valid    = m_valid_q;
        m_data     = m_data_q;
        m_eol      = m_eol_q;
        m_eof      = m_eof_q;
        busy       = busy_q;
        frame_done = frame_done_q;
        hit_count  = hit_cnt_q;
        bg_level   = bg_q;
    end

endmodule

// File: tb/tb_sp_preproc_ctrl.sv
// Directed bench for sp_preproc_ctrl with a 4x2 frame and ALPHA_SH=1.
module tb_sp_preproc_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_addr = 2'd0;
    logic [7:0]  cfg_wdata = 8'd0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [7:0]  s_data = 8'd0;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [7:0]  m_data;
    logic        m_eol;
    logic        m_eof;
    logic        busy;
    logic        frame_done;
    logic [19:0] hit_count;
    logic [7:0]  bg_level;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] px_basic, px_100;
    logic [63:0] exp_basic, exp_low, exp_hi200, exp_100, exp_bg100;

    sp_preproc_ctrl #(.IMG_W(4), .IMG_H(2), .ALPHA_SH(1)) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_eol(m_eol), .m_eof(m_eof),
        .busy(busy), .frame_done(frame_done),
        .hit_count(hit_count), .bg_level(bg_level)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] pk(input logic [7:0] p0, input logic [7:0] p1,
                                       input logic [7:0] p2, input logic [7:0] p3,
                                       input logic [7:0] p4, input logic [7:0] p5,
                                       input logic [7:0] p6, input logic [7:0] p7);
        return {p7, p6, p5, p4, p3, p2, p1, p0};
    endfunction

    task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        s_valid   = 1'b0;
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // Streams one 8-pixel frame, checks every output beat, frame_done count
    // and hit_count during DONE. Optional single config write when the
    // pixel index reaches wr_at.
    task automatic run_frame(input string name, input logic [63:0] px,
                             input logic [63:0] expv, input int exp_hits,
                             input bit stall, input int wr_at,
                             input logic [1:0] wa, input logic [7:0] wd);
        int idx = 0;
        int nout = 0;
        int fd = 0;
        int cyc = 0;
        bit wrote = 1'b0;
        logic [19:0] hc_seen = 20'hFFFFF;
        while ((nout < 8 || fd == 0) && cyc < 200) begin
            @(negedge clk);
            m_ready = stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            cfg_we  = 1'b0;
            if (!wrote && wr_at >= 0 && idx == wr_at) begin
                cfg_we    = 1'b1;
                cfg_addr  = wa;
                cfg_wdata = wd;
                wrote     = 1'b1;
            end
            s_valid = (idx < 8);
            s_data  = (idx < 8) ? px[8*idx +: 8] : 8'h00;
            #1;
            if (frame_done) begin
                fd++;
                hc_seen = hit_count;
            end
            if (m_valid && m_ready && nout < 8) begin
                n_checks++;
                if (m_data !== expv[8*nout +: 8]) begin
                    n_fail++;
                    $display("FAIL %s out%0d data: got %0d expected %0d", name, nout, m_data, expv[8*nout +: 8]);
                end
                n_checks++;
                if (m_eol !== (nout % 4 == 3)) begin
                    n_fail++;
                    $display("FAIL %s out%0d eol: got %b expected %b", name, nout, m_eol, (nout % 4 == 3));
                end
                n_checks++;
                if (m_eof !== (nout == 7)) begin
                    n_fail++;
                    $display("FAIL %s out%0d eof: got %b expected %b", name, nout, m_eof, (nout == 7));
                end
                nout++;
            end
            if (s_valid && s_ready) idx++;
            cyc++;
        end
        n_checks++;
        if (cyc >= 200) begin
            n_fail++;
            $display("FAIL %s timeout: outputs %0d frame_done %0d", name, nout, fd);
        end
        n_checks++;
        if (fd != 1) begin
            n_fail++;
            $display("FAIL %s frame_done pulses: got %0d expected 1", name, fd);
        end
        n_checks++;
        if (hc_seen !== 20'(exp_hits)) begin
            n_fail++;
            $display("FAIL %s hit_count: got %0d expected %0d", name, hc_seen, exp_hits);
        end
        @(negedge clk);
        cfg_we  = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if ({s_ready, m_valid, m_eol, m_eof, busy, frame_done} !== 6'b0 || m_data !== 8'd0 ||
            hit_count !== 20'd0 || bg_level !== 8'd186) begin
            n_fail++;
            $display("FAIL reset values: got rdy%b val%b eol%b eof%b busy%b fd%b data%0d hc%0d bg%0d expected zeros and bg 186",
                     s_ready, m_valid, m_eol, m_eof, busy, frame_done, m_data, hit_count, bg_level);
        end
        rst = 1'b0;
        @(negedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b1 || s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL start after reset: got busy %b s_ready %b expected 1 1", busy, s_ready);
        end
    endtask

    task automatic test_basic();
        run_frame("basic", px_basic, exp_basic, 2, 1'b0, -1, 2'd0, 8'd0);
    endtask

    task automatic test_back_to_back_det_low();
        cfg_write(2'd3, 8'h07);
        run_frame("b2b_default", px_basic, exp_basic, 2, 1'b0, -1, 2'd0, 8'd0);
        cfg_write(2'd3, 8'h03);
        run_frame("det_low", px_basic, exp_low, 4, 1'b0, -1, 2'd0, 8'd0);
    endtask

    task automatic test_backpressure();
        run_frame("stall", px_basic, exp_basic, 2, 1'b1, -1, 2'd0, 8'd0);
    endtask

    task automatic test_midframe_cfg();
        run_frame("midwr_cur", px_basic, exp_basic, 2, 1'b0, 4, 2'd0, 8'd200);
        run_frame("midwr_next", px_basic, exp_hi200, 3, 1'b0, 2, 2'd0, 8'd250);
    endtask

    task automatic test_adapt();
        run_frame("pre_adapt", px_basic, exp_basic, 2, 1'b0, 1, 2'd3, 8'h0B);
        n_checks++;
        if (bg_level !== 8'd186) begin
            n_fail++;
            $display("FAIL adapt bg before: got %0d expected 186", bg_level);
        end
        run_frame("adapt", px_100, exp_100, 0, 1'b0, 1, 2'd3, 8'h03);
        n_checks++;
        if (bg_level !== 8'd100) begin
            n_fail++;
            $display("FAIL adapt bg after: got %0d expected 100", bg_level);
        end
        run_frame("bg100", px_basic, exp_bg100, 2, 1'b0, -1, 2'd0, 8'd0);
    endtask

    task automatic test_disable();
        run_frame("disable", px_basic, exp_bg100, 2, 1'b0, 2, 2'd3, 8'h02);
        #1;
        n_checks++;
        if (busy !== 1'b0 || s_ready !== 1'b0 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL idle after disable: got busy %b s_ready %b fd %b expected 0 0 0", busy, s_ready, frame_done);
        end
        cfg_write(2'd3, 8'h03);
        @(negedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b1 || s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL re-enable: got busy %b s_ready %b expected 1 1", busy, s_ready);
        end
    endtask

    task automatic test_reset_midframe();
        int idx = 0;
        int cyc = 0;
        int fd = 0;
        while (idx < 3 && cyc < 50) begin
            @(negedge clk);
            m_ready = 1'b1;
            s_valid = 1'b1;
            s_data  = px_basic[8*idx +: 8];
            #1;
            if (s_valid && s_ready) idx++;
            cyc++;
        end
        n_checks++;
        if (cyc >= 50) begin
            n_fail++;
            $display("FAIL rst_mid prestream timeout: accepted %0d expected 3", idx);
        end
        @(negedge clk);
        s_valid = 1'b0;
        rst     = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            if (frame_done) fd++;
        end
        n_checks++;
        if ({s_ready, m_valid, m_eol, m_eof, busy} !== 5'b0 || m_data !== 8'd0 ||
            hit_count !== 20'd0 || bg_level !== 8'd186) begin
            n_fail++;
            $display("FAIL rst_mid values: got rdy%b val%b eol%b eof%b busy%b data%0d hc%0d bg%0d expected zeros and bg 186",
                     s_ready, m_valid, m_eol, m_eof, busy, m_data, hit_count, bg_level);
        end
        n_checks++;
        if (fd != 0) begin
            n_fail++;
            $display("FAIL rst_mid frame_done: got %0d pulses expected 0", fd);
        end
        rst = 1'b0;
        run_frame("after_rst", px_basic, exp_basic, 2, 1'b0, -1, 2'd0, 8'd0);
    endtask

    initial begin
        px_basic  = pk(8'd0, 8'd5, 8'd100, 8'd250, 8'd255, 8'd186, 8'd6, 8'd249);
        px_100    = pk(8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100);
        exp_basic = pk(8'd0, 8'd5, 8'd100, 8'd186, 8'd186, 8'd186, 8'd6, 8'd249);
        exp_low   = pk(8'd186, 8'd186, 8'd100, 8'd186, 8'd186, 8'd186, 8'd6, 8'd249);
        exp_hi200 = pk(8'd0, 8'd5, 8'd100, 8'd186, 8'd186, 8'd186, 8'd6, 8'd186);
        exp_100   = px_100;
        exp_bg100 = pk(8'd0, 8'd5, 8'd100, 8'd100, 8'd100, 8'd186, 8'd6, 8'd249);

        test_reset();
        test_basic();
        test_back_to_back_det_low();
        test_backpressure();
        test_midframe_cfg();
        test_adapt();
        test_disable();
        test_reset_midframe();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
